axi4_read_arbiter: RTL

Shares one AXI4 read master port (AR + R channels) between `NUM_REQ` cache requesters, typically ICache (index 0) and DCache (index 1), on the way to the memory interconnect. Grants one requester at a time with round-robin priority, forwards its AR beat, then routes the full R burst back until `r_last`. At most one burst is outstanding. Write channels are not handled here.

---
 rtl/axi4_read_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axi4_read_arbiter.sv
// Purpose: shares one AXI4 read master (AR + R) between NUM_REQ requesters, round-robin, one burst in flight.
// Latency: AR reaches the master port one cycle after it is seen in IDLE; R beats pass through with zero added latency.
// Backpressure: m_ar_ready and the granted req_r_ready pass straight through; non-granted requesters see ready = 0.
//
// Ports:
//   clk, a_rst_n                     clock, asynchronous active-low reset
//   req_ar_* / req_r_*               per-requester AR/R channels (AR payloads packed, requester i at slice i)
//   m_ar_* / m_r_*                   shared downstream AR/R channels; m_ar_id carries the granted index
//   grant_o                          current or most recent owner
//   busy_o                           high whenever a burst is being set up or transferred
module axi4_read_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          a_rst_n,
  // requester AR
  input  logic [NUM_REQ-1:0]            req_ar_valid,
  output logic [NUM_REQ-1:0]            req_ar_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_ar_addr,
  input  logic [NUM_REQ*8-1:0]          req_ar_len,
  input  logic [NUM_REQ*3-1:0]          req_ar_size,
  input  logic [NUM_REQ*2-1:0]          req_ar_burst,
  // requester R
  output logic [NUM_REQ-1:0]            req_r_valid,
  input  logic [NUM_REQ-1:0]            req_r_ready,
  output logic [DATA_WIDTH-1:0]         req_r_data,
  output logic [1:0]                    req_r_resp,
  output logic                          req_r_last,
  // downstream AR
  output logic                          m_ar_valid,
  input  logic                          m_ar_ready,
  output logic [ADDR_WIDTH-1:0]         m_ar_addr,
  output logic [7:0]                    m_ar_len,
  output logic [2:0]                    m_ar_size,
  output logic [1:0]                    m_ar_burst,
  output logic [ID_WIDTH-1:0]           m_ar_id,
  // downstream R
  input  logic                          m_r_valid,
  output logic                          m_r_ready,
  input  logic [DATA_WIDTH-1:0]         m_r_data,
  input  logic [1:0]                    m_r_resp,
  input  logic                          m_r_last,
  // status
  output logic [$clog2(NUM_REQ)-1:0]    grant_o,
  output logic                          busy_o
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [GW-1:0]   grant, grant_d;
  logic [GW-1:0]   last_grant, last_grant_d;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   scan_idx;
  logic            any_vld;

  // Round-robin pick. Scanning from the far end toward last_grant+1 lets the
  // nearest valid requester overwrite farther ones, so no early exit is needed.
  always_comb begin
    winner   = last_grant;
    any_vld  = 1'b0;
    scan_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (req_ar_valid[scan_idx]) begin
        winner  = scan_idx;
        any_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    case (state)
      IDLE: begin
        if (any_vld) begin
          grant_d = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // A requester that drops valid here keeps the grant; no re-arbitration.
        if (m_ar_valid && m_ar_ready) state_d = DATA;
      end
      DATA: begin
        if (m_r_valid && m_r_ready && m_r_last) begin
          state_d      = IDLE;
          last_grant_d = grant;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ar_ready = '0;
    req_r_valid  = '0;
    m_ar_valid   = 1'b0;
    m_r_ready    = 1'b0;
    m_ar_addr    = req_ar_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    m_ar_len     = req_ar_len[grant*8 +: 8];
    m_ar_size    = req_ar_size[grant*3 +: 3];
    m_ar_burst   = req_ar_burst[grant*2 +: 2];
    // ID_WIDTH is assumed to be at least GW; upper bits are zero.
    m_ar_id          = '0;
    m_ar_id[GW-1:0]  = grant;
    case (state)
      ADDR: begin
        m_ar_valid          = req_ar_valid[grant];
        req_ar_ready[grant] = m_ar_ready;
      end
      DATA: begin
        req_r_valid[grant] = m_r_valid;
        m_r_ready          = req_r_ready[grant];
      end
      default: ;
    endcase
  end

  // R payload is broadcast; only the owner's valid is raised.
  assign req_r_data = m_r_data;
  assign req_r_resp = m_r_resp;
  assign req_r_last = m_r_last;

  assign grant_o = grant;
  assign busy_o  = (state != IDLE);

endmodule
